// File: rtl/obf_lut_seq_pkg.sv
// Shared definitions for the sequenced obfuscator substitution LUT: FSM states,
// instruction type codes, class-map field layout and the parity helper.
package obf_lut_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_EMIT   = 2'd2
    } state_e;

    localparam int INSN_TYPE_W = 3;
    localparam int PAYLOAD_W   = 13;

    localparam logic [INSN_TYPE_W-1:0] OBF_INSN_TYPE_ANY    = 3'd0;
    localparam logic [INSN_TYPE_W-1:0] OBF_INSN_TYPE_ALU    = 3'd1;
    localparam logic [INSN_TYPE_W-1:0] OBF_INSN_TYPE_LOAD   = 3'd2;
    localparam logic [INSN_TYPE_W-1:0] OBF_INSN_TYPE_STORE  = 3'd3;
    localparam logic [INSN_TYPE_W-1:0] OBF_INSN_TYPE_BRANCH = 3'd4;

    // Map word is {en, var_log2, len, start}; start is ADDR_W wide, at bit 0
    localparam int MAP_START_LSB = 0;
    localparam int MAP_LEN_W     = 3;
    localparam int MAP_VAR_W     = 2;

    localparam int LUT_DEFAULT_IDX = 0;

    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/obf_lut_ram.sv
// LUT storage with two combinational read ports and one write port.
// With OBF_LUT_SEQ_PARITY_EN defined, each word carries an even-parity bit.
module obf_lut_ram
    import obf_lut_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
`ifdef OBF_LUT_SEQ_PARITY_EN
    ,
    output logic              rpar0,
    output logic [DATA_W-1:0] rdata_dflt
`endif
);
    localparam int DEPTH = 2**ADDR_W;

`ifdef OBF_LUT_SEQ_PARITY_EN
    logic [DATA_W:0] mem_r [DEPTH];

    // Word write with parity generated on the way in
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= {even_parity(64'(wdata)), wdata};
        end
    end

    assign rdata0     = mem_r[raddr0][DATA_W-1:0];
    assign rpar0      = mem_r[raddr0][DATA_W];
    assign rdata1     = mem_r[raddr1][DATA_W-1:0];
    assign rdata_dflt = mem_r[ADDR_W'(LUT_DEFAULT_IDX)][DATA_W-1:0];
`else
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Word write; contents are not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_r[raddr0];
    assign rdata1 = mem_r[raddr1];
`endif

endmodule

// File: rtl/obf_lut_seq.sv
// Sequenced obfuscator substitution LUT: class map -> key-selected variant -> streamed entries.
// Optional LUT parity checking with sticky par_err is enabled by OBF_LUT_SEQ_PARITY_EN.
module obf_lut_seq
    import obf_lut_seq_pkg::*;
#(
    parameter int IDX_W  = 8,
    parameter int KEY_W  = 8,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 6,
    parameter int MAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_index,
    input  logic [KEY_W-1:0]  req_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sub,
    output logic [OUT_W-1:0]  out_imm,
    output logic              out_last,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [OUT_W-1:0]  cfg_wdata,
    output logic              busy,
    output logic              cfg_err
`ifdef OBF_LUT_SEQ_PARITY_EN
    ,
    output logic              par_err
`endif
);
    localparam int MAP_LEN_LSB = MAP_START_LSB + ADDR_W;
    localparam int MAP_VAR_LSB = MAP_LEN_LSB + MAP_LEN_W;
    localparam int MAP_EN_BIT  = MAP_VAR_LSB + MAP_VAR_W;
    localparam int MAP_DATA_W  = MAP_EN_BIT;
    localparam int MAP_DEPTH   = 2**MAP_W;
    localparam int VARIANT_W   = (1 << MAP_VAR_W) - 1;
    localparam int PROD_W      = VARIANT_W + MAP_LEN_W;

    localparam logic [MAP_LEN_W-1:0] LEN_ONE  = MAP_LEN_W'(1);
    localparam logic [ADDR_W-1:0]    ADDR_ONE = ADDR_W'(1);
    localparam logic [VARIANT_W:0]   VAR_ONE  = (VARIANT_W+1)'(1);

    state_e state_r, state_nx_s;

    logic [IDX_W-1:0]      index_r;
    logic [KEY_W-1:0]      key_r;
    logic [ADDR_W-1:0]     base_r;
    logic [MAP_LEN_W-1:0]  len_r;
    logic [MAP_LEN_W-1:0]  cnt_r;
    logic                  out_valid_r, out_last_r, busy_r, req_ready_r, cfg_err_r;
    logic [OUT_W-1:0]      out_sub_r, out_imm_r;

    logic [MAP_DATA_W-1:0] map_data_r [MAP_DEPTH];
    logic [MAP_DEPTH-1:0]  map_en_r;

    logic                  accept_s, load_s, cfg_ok_s, lut_we_s, map_we_s;
    logic [MAP_W-1:0]      map_idx_s;
    logic [MAP_DATA_W-1:0] map_word_s;
    logic [ADDR_W-1:0]     start_s, base_raw_s, base_s, rd_addr_s;
    logic [MAP_LEN_W-1:0]  len_s, len_eff_s, len_nx_s, cnt_nx_s;
    logic [MAP_VAR_W-1:0]  var_log2_s;
    logic [VARIANT_W:0]    mask_full_s;
    logic [VARIANT_W-1:0]  variant_s;
    logic [PROD_W-1:0]     prod_s;
    logic                  mapped_s, last_nx_s, last_s;
    logic [OUT_W-1:0]      rd_sub_s, rd_imm_s, sub_nx_s;
    logic                  unused_s;

    assign accept_s = (state_r == ST_IDLE) && req_valid && req_ready_r;
    assign cfg_ok_s = cfg_we && !busy_r && !accept_s;
    assign lut_we_s = cfg_ok_s && !cfg_sel;
    assign map_we_s = cfg_ok_s && cfg_sel;

    // Class-map decode and variant base address
    assign map_idx_s   = index_r[MAP_W-1:0];
    assign map_word_s  = map_data_r[map_idx_s];
    assign start_s     = map_word_s[MAP_START_LSB +: ADDR_W];
    assign len_s       = map_word_s[MAP_LEN_LSB +: MAP_LEN_W];
    assign var_log2_s  = map_word_s[MAP_VAR_LSB +: MAP_VAR_W];
    assign mask_full_s = (VAR_ONE << var_log2_s) - VAR_ONE;
    assign variant_s   = key_r[VARIANT_W-1:0] & mask_full_s[VARIANT_W-1:0];
    assign prod_s      = PROD_W'(variant_s) * PROD_W'(len_s);
    assign base_raw_s  = start_s + ADDR_W'(prod_s);
    assign mapped_s    = map_en_r[map_idx_s] && (len_s != {MAP_LEN_W{1'b0}});
    assign base_s      = mapped_s ? base_raw_s : ADDR_W'(LUT_DEFAULT_IDX);
    assign len_eff_s   = mapped_s ? len_s : LEN_ONE;

    assign unused_s = ^{index_r[IDX_W-1:MAP_W], key_r[KEY_W-1:VARIANT_W], mask_full_s[VARIANT_W]};

    // Address, count and last flag of the beat loaded at the next edge
    always_comb begin
        if (state_r == ST_LOOKUP) begin
            rd_addr_s = base_s;
            cnt_nx_s  = {MAP_LEN_W{1'b0}};
            len_nx_s  = len_eff_s;
        end else begin
            rd_addr_s = base_r + ADDR_W'(cnt_r) + ADDR_ONE;
            cnt_nx_s  = cnt_r + LEN_ONE;
            len_nx_s  = len_r;
        end
        last_nx_s = (cnt_nx_s == (len_nx_s - LEN_ONE));
    end

`ifdef OBF_LUT_SEQ_PARITY_EN
    logic             rd_par_s, par_bad_s, par_err_r;
    logic [OUT_W-1:0] rd_dflt_s;

    assign par_bad_s = (even_parity(64'(rd_sub_s)) != rd_par_s);
    assign par_err   = par_err_r;

    // A parity fault substitutes the default entry and ends the sequence
    always_comb begin
        if (par_bad_s) begin
            sub_nx_s = rd_dflt_s;
            last_s   = 1'b1;
        end else begin
            sub_nx_s = rd_sub_s;
            last_s   = last_nx_s;
        end
    end

    // Sticky parity error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_r <= 1'b0;
        end else if (load_s && par_bad_s) begin
            par_err_r <= 1'b1;
        end
    end
`else
    assign sub_nx_s = rd_sub_s;
    assign last_s   = last_nx_s;
`endif

    obf_lut_ram #(
        .DATA_W (OUT_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk        (clk),
        .we         (lut_we_s),
        .waddr      (cfg_addr),
        .wdata      (cfg_wdata),
        .raddr0     (rd_addr_s),
        .raddr1     (rd_addr_s + ADDR_ONE),
        .rdata0     (rd_sub_s),
        .rdata1     (rd_imm_s)
`ifdef OBF_LUT_SEQ_PARITY_EN
        ,
        .rpar0      (rd_par_s),
        .rdata_dflt (rd_dflt_s)
`endif
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state and beat-load strobe
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_LOOKUP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                load_s     = 1'b1;
                state_nx_s = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready && out_last_r) begin
                    state_nx_s = ST_IDLE;
                end else if (out_ready) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_EMIT;
                end else begin
                    state_nx_s = ST_EMIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Request capture, sequence bookkeeping and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_r     <= {IDX_W{1'b0}};
            key_r       <= {KEY_W{1'b0}};
            base_r      <= {ADDR_W{1'b0}};
            len_r       <= {MAP_LEN_W{1'b0}};
            cnt_r       <= {MAP_LEN_W{1'b0}};
            out_valid_r <= 1'b0;
            out_sub_r   <= {OUT_W{1'b0}};
            out_imm_r   <= {OUT_W{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
            cfg_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                index_r <= req_index;
                key_r   <= req_key;
            end
            if (state_r == ST_LOOKUP) begin
                base_r <= base_s;
                len_r  <= len_eff_s;
            end
            if (load_s) begin
                cnt_r      <= cnt_nx_s;
                out_sub_r  <= sub_nx_s;
                out_imm_r  <= rd_imm_s;
                out_last_r <= last_s;
            end
            out_valid_r <= (state_nx_s == ST_EMIT);
            busy_r      <= (state_nx_s != ST_IDLE);
            req_ready_r <= (state_nx_s == ST_IDLE);
            cfg_err_r   <= cfg_we && (busy_r || accept_s);
        end
    end

    // Class-map enables; cleared by reset so every class starts unmapped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_en_r <= {MAP_DEPTH{1'b0}};
        end else if (map_we_s) begin
            map_en_r[cfg_addr[MAP_W-1:0]] <= cfg_wdata[MAP_EN_BIT];
        end
    end

    // Class-map fields; meaningless while the enable is clear, so not reset
    always_ff @(posedge clk) begin
        if (map_we_s) begin
            map_data_r[cfg_addr[MAP_W-1:0]] <= cfg_wdata[MAP_DATA_W-1:0];
        end
    end

    assign req_ready = req_ready_r;
    assign out_valid = out_valid_r;
    assign out_sub   = out_sub_r;
    assign out_imm   = out_imm_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: doc/obf_lut_seq.md
Name: obf_lut_seq

Overview:
Programmable, sequenced successor to the obfuscator substitution LUT. It takes an instruction-class index and a key from the IGU. It resolves a class map entry to a key-selected variant of a substitution sequence. It then streams the sequence one entry per handshake, giving both the current and the next entry as the sub and imm words, to the decode-side insertion logic. LUT and class map are run-time writable through a config port instead of fixed at elaboration.

Parameters:
IDX_W, 8, width of req_index (matches OBF_IGU_WIDTH)
KEY_W, 8, width of req_key
OUT_W, 16, LUT entry width (type field + 13-bit payload)
ADDR_W, 6, LUT address width; depth = 2**ADDR_W
MAP_W, 4, class-map address width; map entries = 2**MAP_W, indexed by req_index[MAP_W-1:0]

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  substitution request
req_ready  out  1  block idle, request can be accepted
req_index  in  IDX_W  instruction class index
req_key  in  KEY_W  obfuscation key
out_valid  out  1  out_sub/out_imm valid
out_ready  in  1  consumer accepts current entry
out_sub  out  OUT_W  current sequence entry
out_imm  out  OUT_W  entry at addr+1 (mod depth)
out_last  out  1  current entry is the final one of the sequence
cfg_we  in  1  config write strobe
cfg_sel  in  1  0 = LUT, 1 = class map
cfg_addr  in  ADDR_W  write address (map uses low MAP_W bits)
cfg_wdata  in  OUT_W  LUT word, or map word {en[1], var_log2[2], len[3], start[ADDR_W]} in the low bits
busy  out  1  sequence in progress (state != IDLE)
cfg_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- FSM states: IDLE, LOOKUP, EMIT. Reset puts the FSM in IDLE.
- Reset values: out_valid=0, out_sub=0, out_imm=0, out_last=0, cfg_err=0, busy=0; req_ready=1 once out of reset. Map en bits clear on reset; LUT contents are retained.
- IDLE: req_ready=1. On req_valid&req_ready, register the index and key and go to LOOKUP.
- LOOKUP: read the map entry (one cycle) and compute base:
  - variant = key & ((1<<var_log2)-1)
  - base = start + variant*len, truncated to ADDR_W (wraps mod depth)
  - cnt=0, then go to EMIT.
- Unmapped class (en=0 or len=0): base=0, len=1. This emits LUT[0], the pass-through "any" entry, with out_last=1.
- EMIT: addr = base + cnt (mod depth). out_sub=LUT[addr], out_imm=LUT[addr+1 mod depth], out_valid=1, out_last=(cnt==len-1).
  - Outputs are held stable while out_ready=0.
  - Handshake, not last: cnt+1.
  - Handshake on last: go to IDLE, out_valid=0 next cycle.
- Latency: request accepted in cycle 0, first out_valid in cycle 2. Successive entries can be accepted one per cycle. The next request is accepted no earlier than the cycle after the last handshake.
- Config:
  - cfg_we while busy=0: the write commits at the clock edge.
  - cfg_we while busy=1, or in the cycle a request is accepted: write ignored, cfg_err pulses 1 cycle.
  - A map write with len=0 is legal and behaves as unmapped.
- Reset mid-sequence: immediate return to IDLE. No partial output is qualified afterwards.

Optional Feature:
OBF_LUT_SEQ_PARITY_EN:
- When defined: each LUT word stores an extra even-parity bit, computed at write time. In EMIT, out_sub parity is checked.
  - On mismatch: output par_err (1 bit, sticky, cleared only by rst) sets, out_sub is forced to LUT[0], and out_last=1 so the sequence aborts cleanly.
- When undefined: no parity storage and no par_err port. Behaviour is otherwise identical.

Decomposition:
- Shared defines file (obf_defines): state encodings, OBF_INSN_TYPE_* codes, map-word field offsets and widths, LUT default entry index 0.
- One sub-module is natural: obf_lut_ram, a 2-read/1-write register array (ports addr, addr+1, write) with the optional parity column.
- FSM, map and address arithmetic stay in obf_lut_seq.

Test Plan:
- Unmapped index 0x40 after reset (map empty): out_valid in cycle 2, out_sub=LUT[0], out_last=1, single beat, then req_ready=1.
- Map[0]={en=1, var_log2=2, len=3, start=1}, key=0x02 -> base=7; three beats with out_sub=LUT[7], LUT[8], LUT[9]; out_imm=LUT[8], LUT[9], LUT[10]; out_last only on the third beat.
- Wrap: start=62, len=3, key=0, ADDR_W=6 -> addresses 62, 63, 0; out_imm on the last beat = LUT[1].
- Backpressure: hold out_ready=0 for 4 cycles mid-sequence -> out_sub/out_imm/out_last stable; cnt does not advance.
- cfg_we to LUT[8] during EMIT -> cfg_err pulses once, LUT[8] unchanged. The same write while idle -> committed, cfg_err=0.
- Assert rst during the second beat -> outputs zero, FSM in IDLE, map en bits cleared; a subsequent request to the previously mapped index returns LUT[0].
